// File: rtl/data_memory_ctrl.sv
// Line-granular main-memory model: one request in flight, ack pulse LATENCY cycles after acceptance, no backpressure
// (new requests are taken only in IDLE). `DMEM_RANGE_CHECK_EN makes out-of-range lines read zero and drop writes.
module data_memory_ctrl #(
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10,
   parameter int DATA_W  = 256,
   parameter int ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              ack_o,
   output logic              busy_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [IW-1:0]       idx_q;
   logic                wr_q;
   logic                oor_q;
   logic [DATA_W-1:0]   wdat_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept;
   logic                enter_ack;
   logic                commit;
   logic [IW-1:0]       idx_in;
   logic                oor_in;
   logic [IW-1:0]       cmd_idx;
   logic                cmd_wr;
   logic                cmd_oor;
   logic [DATA_W-1:0]   cmd_dat;

   assign idx_in = addr_i[5+IW-1:5];

`ifdef DMEM_RANGE_CHECK_EN
   assign oor_in = |addr_i[ADDR_W-1:5+IW];
   logic unused_addr;
   assign unused_addr = ^addr_i[4:0];
`else
   assign oor_in = 1'b0;
   logic unused_addr;
   assign unused_addr = ^{addr_i[ADDR_W-1:5+IW], addr_i[4:0]};
`endif

   assign accept = (state_q == S_IDLE) && enable_i;

   // With LATENCY=1 the commit happens on the acceptance edge, so take the command straight from the inputs.
   assign cmd_idx = (state_q == S_IDLE) ? idx_in  : idx_q;
   assign cmd_wr  = (state_q == S_IDLE) ? write_i : wr_q;
   assign cmd_oor = (state_q == S_IDLE) ? oor_in  : oor_q;
   assign cmd_dat = (state_q == S_IDLE) ? data_i  : wdat_q;
   assign commit  = enter_ack && rst_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      enter_ack = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable_i) begin
               count_d = CW'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d   = S_ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (count_q == CW'(1)) begin
               state_d   = S_ACK;
               enter_ack = 1'b1;
            end else begin
               count_d = count_q - CW'(1);
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ack_o  = (state_q == S_ACK);
      busy_o = (state_q != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idx_q  <= '0;
         wr_q   <= 1'b0;
         oor_q  <= 1'b0;
         wdat_q <= '0;
         data_q <= '0;
      end else begin
         if (accept) begin
            idx_q  <= idx_in;
            wr_q   <= write_i;
            oor_q  <= oor_in;
            wdat_q <= data_i;
         end
         if (enter_ack && !cmd_wr) begin
            data_q <= cmd_oor ? '0 : mem_q[cmd_idx];
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (commit && cmd_wr && !cmd_oor) begin
         mem_q[cmd_idx] <= cmd_dat;
      end
   end

   assign data_o = data_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one LATENCY=10 instance and one LATENCY=3 instance for back-to-back timing.
module tb_data_memory_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en10, en3, wr;
   logic [31:0]  addr;
   logic [255:0] wdat;
   logic [255:0] rd10, rd3;
   logic         ack10, ack3, busy10, busy3;
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH(512), .LATENCY(10), .DATA_W(256), .ADDR_W(32)) u_dut10 (
      .clk_i(clk), .rst_i(rst_n), .enable_i(en10), .write_i(wr), .addr_i(addr),
      .data_i(wdat), .data_o(rd10), .ack_o(ack10), .busy_o(busy10));

   data_memory_ctrl #(.DEPTH(512), .LATENCY(3), .DATA_W(256), .ADDR_W(32)) u_dut3 (
      .clk_i(clk), .rst_i(rst_n), .enable_i(en3), .write_i(wr), .addr_i(addr),
      .data_i(wdat), .data_o(rd3), .ack_o(ack3), .busy_o(busy3));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request; if mangle is set, all inputs are scrambled right after acceptance.
   task automatic req(input bit d3, input bit w, input logic [31:0] a, input logic [255:0] d,
                      input bit mangle, input int exp_lat, input string tag,
                      output logic [255:0] rdata);
      int n;
      logic got;
      wr = w; addr = a; wdat = d;
      if (d3) en3 = 1'b1; else en10 = 1'b1;
      tick();
      en3 = 1'b0; en10 = 1'b0;
      if (mangle) begin
         addr = a + 32'h20; wdat = ~d; wr = ~w;
      end
      n = 1;
      got = d3 ? ack3 : ack10;
      while (!got && n < 100) begin
         tick();
         n++;
         got = d3 ? ack3 : ack10;
      end
      rdata = d3 ? rd3 : rd10;
      chk({tag, "_lat"}, 256'(n), 256'(exp_lat));
      tick();
      chk({tag, "_ackw"}, {255'b0, (d3 ? ack3 : ack10)}, 256'b0);
   endtask

   initial begin
      logic [255:0] r;
      logic         any_ack, any_busy, any_data;
      int           ack_cnt, first_at, second_at;
      logic [255:0] first_d, second_d;

      rst_n = 1'b0; en10 = 1'b0; en3 = 1'b0; wr = 1'b0; addr = '0; wdat = '0;
      #1;
      chk("rst_ack", {255'b0, ack10}, 256'b0);
      chk("rst_busy", {255'b0, busy10}, 256'b0);
      chk("rst_data", rd10, 256'b0);
      tick(); tick();
      rst_n = 1'b1;

      // Idle with enable low
      any_ack = 1'b0; any_busy = 1'b0; any_data = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         any_ack  |= ack10;
         any_busy |= busy10;
         any_data |= |rd10;
      end
      chk("idle_ack", {255'b0, any_ack}, 256'b0);
      chk("idle_busy", {255'b0, any_busy}, 256'b0);
      chk("idle_data", {255'b0, any_data}, 256'b0);

      // Write then read the same line
      req(1'b0, 1'b1, 32'h0000_0040, {8{32'hDEADBEEF}}, 1'b0, 10, "wr40", r);
      req(1'b0, 1'b0, 32'h0000_0040, '0, 1'b0, 10, "rd40", r);
      chk("rd40_data", r, {8{32'hDEADBEEF}});
      chk("idle_after_busy", {255'b0, busy10}, 256'b0);

      // Back-to-back reads on the LATENCY=3 instance
      req(1'b1, 1'b1, 32'h0000_0000, {8{32'h0A0A0A0A}}, 1'b0, 3, "d3wr0", r);
      req(1'b1, 1'b1, 32'h0000_0020, {8{32'h0B0B0B0B}}, 1'b0, 3, "d3wr1", r);
      wr = 1'b0; addr = 32'h0; en3 = 1'b1;
      ack_cnt = 0; first_at = 0; second_at = 0; first_d = '0; second_d = '0;
      for (int n = 1; n <= 7; n++) begin
         tick();
         if (ack3) begin
            ack_cnt++;
            if (ack_cnt == 1) begin
               first_at = n; first_d = rd3; addr = 32'h20;
            end else begin
               second_at = n; second_d = rd3;
            end
         end
      end
      en3 = 1'b0;
      tick(); tick();
      chk("b2b_first_at", 256'(first_at), 256'd3);
      chk("b2b_second_at", 256'(second_at), 256'd7);
      chk("b2b_ack_cycles", 256'(ack_cnt), 256'd2);
      chk("b2b_first_data", first_d, {8{32'h0A0A0A0A}});
      chk("b2b_second_data", second_d, {8{32'h0B0B0B0B}});
      chk("b2b_idle", {255'b0, busy3}, 256'b0);

      // Input changes during WAIT are ignored
      req(1'b0, 1'b1, 32'h0000_00A0, {8{32'h55555555}}, 1'b0, 10, "wrA0", r);
      req(1'b0, 1'b1, 32'h0000_0080, {8{32'h44444444}}, 1'b1, 10, "wr80_mangled", r);
      req(1'b0, 1'b0, 32'h0000_0080, '0, 1'b0, 10, "rd80", r);
      chk("rd80_data", r, {8{32'h44444444}});
      req(1'b0, 1'b0, 32'h0000_00A0, '0, 1'b0, 10, "rdA0", r);
      chk("rdA0_data", r, {8{32'h55555555}});

      // Reset in the middle of a write
      req(1'b0, 1'b1, 32'h0000_0100, 256'h77, 1'b0, 10, "wr100_old", r);
      wr = 1'b1; addr = 32'h100; wdat = 256'h1; en10 = 1'b1;
      tick();
      en10 = 1'b0;
      chk("abort_busy_pre", {255'b0, busy10}, 256'b1);
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {255'b0, busy10}, 256'b0);
      chk("abort_data", rd10, 256'b0);
      tick();
      rst_n = 1'b1;
      any_ack = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         any_ack |= ack10;
      end
      chk("abort_no_ack", {255'b0, any_ack}, 256'b0);
      req(1'b0, 1'b0, 32'h0000_0100, '0, 1'b0, 10, "rd100", r);
      chk("rd100_data", r, 256'h77);

      // Address above the index range
      req(1'b0, 1'b1, 32'h0000_0000, 256'hC0, 1'b0, 10, "wr0", r);
      req(1'b0, 1'b1, 32'h0000_4000, 256'h5, 1'b0, 10, "wr4000", r);
      req(1'b0, 1'b0, 32'h0000_0000, '0, 1'b0, 10, "rd0", r);
`ifdef DMEM_RANGE_CHECK_EN
      chk("rd0_data", r, 256'hC0);
`else
      chk("rd0_data", r, 256'h5);
`endif
      req(1'b0, 1'b0, 32'h0000_4000, '0, 1'b0, 10, "rd4000", r);
`ifdef DMEM_RANGE_CHECK_EN
      chk("rd4000_data", r, 256'h0);
`else
      chk("rd4000_data", r, 256'h5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Line-granular (256-bit) main-memory model and controller on the data-cache refill/write-back path, directly downstream of the CPU's mem_* interface.
- Accepts one read or write request at a time over an enable/ack handshake.
- Completes each request after a fixed, parameterised latency, with a single-cycle ack pulse.
- Owns the backing storage array.

Parameters:
- DEPTH, 512, number of 256-bit lines in storage (power of two, ≥2).
- LATENCY, 10, cycles from request acceptance to ack (≥1).
- DATA_W, 256, line width in bits (fixed 256; parameter for documentation only).
- ADDR_W, 32, byte-address width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  request valid from CPU/dcache (mem_enable_o).
- write_i  in  1  1 = write line, 0 = read line (mem_write_o).
- addr_i  in  ADDR_W  byte address (mem_addr_o); bits [4:0] ignored.
- data_i  in  DATA_W  write line data (mem_data_o).
- data_o  out  DATA_W  read line data (to mem_data_i).
- ack_o  out  1  one-cycle completion pulse (to mem_ack_i).
- busy_o  out  1  high while a request is in flight (states WAIT and ACK).

Behaviour:
- Reset values, asserted asynchronously:
  - State IDLE; count 0; ack_o 0; busy_o 0; data_o 0.
  - Latched addr/data/write cleared.
  - Storage array is not reset.
- Line index = addr_i[5+IW-1:5], where IW = log2(DEPTH). Upper address bits are handled per Optional Feature.
- State machine:
  - IDLE: if enable_i = 1 at a clock edge, latch index, write_i and data_i; count = LATENCY-1; go to WAIT (if LATENCY = 1, go directly to ACK).
  - WAIT: decrement count each cycle; when count reaches 1, go to ACK.
  - ACK: ack_o = 1 for exactly this cycle; return to IDLE.
- Latency: enable_i first sampled high at edge T → ack_o high during the cycle after edge T+LATENCY-1 (i.e. ack_o is visible LATENCY cycles after acceptance). Bench counts edges from the acceptance edge.
- Read completion: data_o loads mem[index] on the edge entering ACK and holds that value until the next read completes. data_o is guaranteed valid only while ack_o = 1.
- Write completion: mem[index] is written with the latched data on the edge entering ACK. data_o is unchanged by writes.
- Inputs are sampled only at acceptance; changes to enable_i/addr_i/data_i/write_i during WAIT/ACK are ignored. Dropping enable_i mid-transaction does not abort the transaction.
- Back-to-back requests: if enable_i is still high in the IDLE cycle after ACK, a new request is accepted. Minimum spacing between acks is LATENCY+1 cycles.
- Read after write to the same line returns the newly written data.
- Reset mid-transaction: transaction aborted; no write committed; no ack issued.
- busy_o = 1 in WAIT and ACK, 0 in IDLE.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - Any address with nonzero bits above index bit 5+IW-1 is out of range.
  - Out-of-range write: storage untouched.
  - Out-of-range read: returns all zeros.
  - Handshake timing is unchanged; ack is still issued.
- Undefined: upper bits are ignored and the index wraps modulo DEPTH.

Test Plan:
1. Reset then idle (LATENCY=10): rst_i low, then high; hold enable_i=0 for 20 cycles → ack_o=0, busy_o=0, data_o=0 throughout.
2. Write then read, same address: write addr 0x0000_0040 with data {8{32'hDEADBEEF}}, ack after exactly 10 cycles; then read addr 0x0000_0040 → ack at 10 cycles, data_o={8{32'hDEADBEEF}}.
3. Back-to-back with enable held high (LATENCY=3): read line 0 then read line 1 → acks on cycles 3 and 7 after the first acceptance; each ack exactly 1 cycle wide.
4. Input changes ignored: accept a write to 0x80, then change addr_i to 0xA0 and drop enable_i during WAIT → line 4 written, line 5 unchanged, ack still issued.
5. Reset mid-transaction: accept a write to 0x100 with 256'h1; assert rst_i at cycle 5 → no ack; a subsequent read of 0x100 returns the old contents.
6. Out-of-range write (DEPTH=512): write 0x0000_4000 with 256'h5 → without macro, line 0 = 256'h5; with DMEM_RANGE_CHECK_EN, line 0 unchanged and a read of 0x4000 returns 0.
